// File: rtl/dm_write_buffer.sv
// Store buffer between the MEM stage and a slow handshaked data memory.
// Stores queue in a circular FIFO; loads forward from it or miss to memory.
module dm_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 10,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     core_we,
    input  logic                     core_re,
    input  logic [AW-1:0]            core_addr,
    input  logic [DW-1:0]            core_wdata,
    output logic [DW-1:0]            core_rdata,
    output logic                     core_stall,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [AW-1:0]            mem_addr,
    output logic [DW-1:0]            mem_wdata,
    input  logic                     mem_ack,
    input  logic [DW-1:0]            mem_rdata,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, WR, RD} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q [DEPTH];
    logic [AW-1:0] addr_d [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [DW-1:0] data_d [DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] raddr_q, raddr_d;

    logic          full, pop, enq, load, hit, load_miss, rd_done;
    logic [DW-1:0] fwd_data;

    assign full      = (count_q == CW'(DEPTH));
    assign pop       = (state_q == WR) && mem_ack;
    assign rd_done   = (state_q == RD) && mem_ack;
    assign enq       = core_we && (!full || pop);
    assign load      = core_re && !core_we;
    assign load_miss = load && !hit;

    // Walk oldest to youngest so the last match is the youngest store.
    always_comb begin
        hit      = 1'b0;
        fwd_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (CW'(k) < count_q && addr_q[head_q + PW'(k)] == core_addr) begin
                hit      = 1'b1;
                fwd_data = data_q[head_q + PW'(k)];
            end
        end
    end

    always_comb begin
        core_rdata = '0;
        if (load) begin
            if (hit)          core_rdata = fwd_data;
            else if (rd_done) core_rdata = mem_rdata;
        end
    end

    assign core_stall = (core_we && !enq) || (load_miss && !rd_done);

    always_comb begin
        addr_d  = addr_q;
        data_d  = data_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (enq) begin
            addr_d[tail_q] = core_addr;
            data_d[tail_q] = core_wdata;
            tail_d         = tail_q + 1'b1;
        end
        if (pop) head_d = head_q + 1'b1;
        case ({enq, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // A pending load miss wins over draining; an in-flight write is never cut short.
    always_comb begin
        state_d = state_q;
        raddr_d = raddr_q;
        case (state_q)
            IDLE: begin
                if (load_miss) begin
                    state_d = RD;
                    raddr_d = core_addr;
                end else if (count_q != '0) begin
                    state_d = WR;
                end
            end
            WR: begin
                if (mem_ack) begin
                    if (load_miss) begin
                        state_d = RD;
                        raddr_d = core_addr;
                    end else if (count_d != '0) begin
                        state_d = WR;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            RD: begin
                if (mem_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            raddr_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                addr_q[k] <= '0;
                data_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            raddr_q <= raddr_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // Memory side is a pure decode of registered state, so reset drops it at once.
    assign mem_req   = (state_q != IDLE);
    assign mem_we    = (state_q == WR);
    assign mem_addr  = (state_q == WR) ? addr_q[head_q] :
                       (state_q == RD) ? raddr_q : '0;
    assign mem_wdata = (state_q == WR) ? data_q[head_q] : '0;
    assign empty     = (count_q == '0);
    assign count     = count_q;

endmodule

// File: tb/tb_dm_write_buffer.sv
// Directed and randomized checks of dm_write_buffer against a scoreboard
// holding the architectural memory image and the queue of unretired stores.
module tb_dm_write_buffer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        core_we = 1'b0, core_re = 1'b0;
    logic [9:0]  core_addr = '0;
    logic [31:0] core_wdata = '0;
    logic [31:0] core_rdata;
    logic        core_stall;
    logic        mem_req, mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        empty;
    logic [2:0]  count;

    int tests = 0;
    int fails = 0;

    typedef struct {logic [9:0] a; logic [31:0] d;} ent_t;
    ent_t        q[$];
    logic [31:0] arch [1024];
    logic [31:0] bmem [1024];

    dm_write_buffer dut (
        .clk(clk), .rst(rst), .core_we(core_we), .core_re(core_re),
        .core_addr(core_addr), .core_wdata(core_wdata), .core_rdata(core_rdata),
        .core_stall(core_stall), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .empty(empty), .count(count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [9:0] a, input logic [31:0] d);
        core_we = 1'b1; core_re = 1'b0; core_addr = a; core_wdata = d;
        #1 chk("store_nostall", core_stall, 0);
        tick();
        core_we = 1'b0;
    endtask

    initial begin
        logic        hold, exp_hit, wr_ack, rd_ack;
        logic [31:0] exp_fwd;
        int          r;

        // reset / idle
        #2;
        chk("rst_req", mem_req, 0);
        chk("rst_empty", empty, 1);
        chk("rst_count", count, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_req", mem_req, 0);
            chk("idle_stall", core_stall, 0);
            chk("idle_count", count, 0);
        end

        // single store with ack tied high
        mem_ack = 1'b1;
        store(10'h004, 32'h11111111);
        #1 chk("s1_count", count, 1);
        chk("s1_req_idle", mem_req, 0);
        tick();
        chk("s1_req", mem_req, 1);
        chk("s1_we", mem_we, 1);
        chk("s1_addr", mem_addr, 10'h004);
        chk("s1_wdata", mem_wdata, 32'h11111111);
        tick();
        chk("s1_drained", count, 0);
        chk("s1_idle", mem_req, 0);
        mem_ack = 1'b0;

        // fill to full, fifth store stalls until a pop frees a slot
        for (int i = 0; i < 4; i++) store(10'h010 + 10'(i), 32'h100 + 32'(i));
        core_we = 1'b1; core_addr = 10'h014; core_wdata = 32'h104;
        #1 chk("full_stall", core_stall, 1);
        tick();
        chk("full_stall2", core_stall, 1);
        chk("full_count", count, 4);
        mem_ack = 1'b1;
        #1 chk("full_release", core_stall, 0);
        chk("drain0", mem_addr, 10'h010);
        tick();
        core_we = 1'b0;
        #1 chk("full_count_kept", count, 4);
        for (int i = 1; i < 5; i++) begin
            chk("drain_addr", mem_addr, 10'h010 + 10'(i));
            chk("drain_data", mem_wdata, 32'h100 + 32'(i));
            chk("drain_we", mem_we, 1);
            tick();
        end
        chk("drain_empty", count, 0);
        chk("drain_idle", mem_req, 0);
        mem_ack = 1'b0;

        // youngest-match forwarding
        store(10'h020, 32'hA);
        store(10'h020, 32'hB);
        core_re = 1'b1; core_addr = 10'h020;
        #1 chk("fwd_data", core_rdata, 32'hB);
        chk("fwd_stall", core_stall, 0);
        tick();
        core_re = 1'b0;
        mem_ack = 1'b1;
        for (int i = 0; i < 2; i++) begin
            chk("fwd_no_rd", mem_we, 1);
            tick();
        end
        chk("fwd_drained", count, 0);
        mem_ack = 1'b0;

        // load miss behind an in-flight write
        store(10'h040, 32'h1);
        store(10'h041, 32'h2);
        core_re = 1'b1; core_addr = 10'h030;
        #1 chk("miss_stall", core_stall, 1);
        tick();
        chk("miss_wr_addr", mem_addr, 10'h040);
        mem_ack = 1'b1;
        #1 chk("miss_stall_wr_ack", core_stall, 1);
        tick();
        mem_ack = 1'b0;
        #1 chk("rd_we", mem_we, 0);
        chk("rd_req", mem_req, 1);
        chk("rd_addr", mem_addr, 10'h030);
        chk("rd_wdata", mem_wdata, 0);
        chk("rd_stall", core_stall, 1);
        tick();
        mem_rdata = 32'hDEADBEEF; mem_ack = 1'b1;
        #1 chk("rd_data", core_rdata, 32'hDEADBEEF);
        chk("rd_unstall", core_stall, 0);
        tick();
        core_re = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        #1 chk("rd_after_count", count, 1);
        tick();
        chk("rest_addr", mem_addr, 10'h041);
        chk("rest_we", mem_we, 1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("rest_empty", empty, 1);

        // reset in the middle of a write
        for (int i = 0; i < 3; i++) store(10'h050 + 10'(i), 32'h50 + 32'(i));
        #1 chk("pre_rst_count", count, 3);
        chk("pre_rst_req", mem_req, 1);
        rst = 1'b1;
        #1 chk("mid_rst_req", mem_req, 0);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_empty", empty, 1);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_req", mem_req, 0);
        end

        // randomized traffic against the scoreboard
        for (int i = 0; i < 1024; i++) begin
            arch[i] = '0;
            bmem[i] = '0;
        end
        hold = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if (!hold) begin
                r = $urandom_range(0, 3);
                core_we = (r == 1) || (r == 3);
                core_re = (r == 2) || (r == 3);
                core_addr = 10'($urandom_range(0, 7));
                core_wdata = $urandom;
            end
            mem_ack = ($urandom_range(0, 2) == 0);
            mem_rdata = bmem[mem_addr];
            #2;
            exp_hit = 1'b0;
            exp_fwd = '0;
            foreach (q[k]) if (q[k].a == core_addr) begin
                exp_hit = 1'b1;
                exp_fwd = q[k].d;
            end
            wr_ack = mem_req && mem_we && mem_ack;
            rd_ack = mem_req && !mem_we && mem_ack;
            chk("r_count", count, q.size());
            chk("r_empty", empty, q.size() == 0);
            if (core_we) begin
                chk("r_st_stall", core_stall, (q.size() == 4) && !wr_ack);
                if (core_re) chk("r_both_rdata", core_rdata, 0);
            end else if (core_re) begin
                chk("r_ld_stall", core_stall, !(exp_hit || rd_ack));
                if (!core_stall) chk("r_ld_data", core_rdata, arch[core_addr]);
                if (exp_hit) chk("r_ld_fwd", core_rdata, exp_fwd);
                if (mem_req && !mem_we) chk("r_rd_addr", mem_addr, core_addr);
            end else begin
                chk("r_idle_rdata", core_rdata, 0);
            end
            if (wr_ack) begin
                if (q.size() == 0) begin
                    chk("r_wr_unexpected", 1, 0);
                end else begin
                    chk("r_wr_addr", mem_addr, q[0].a);
                    chk("r_wr_data", mem_wdata, q[0].d);
                    bmem[mem_addr] = mem_wdata;
                    void'(q.pop_front());
                end
            end
            if (core_we && !core_stall) begin
                q.push_back('{a: core_addr, d: core_wdata});
                arch[core_addr] = core_wdata;
            end
            hold = core_stall;
            tick();
        end

        // drain and compare memory image
        core_we = 1'b0; core_re = 1'b0; mem_ack = 1'b1;
        for (int c = 0; c < 20; c++) begin
            #2;
            if (mem_req && mem_we) bmem[mem_addr] = mem_wdata;
            tick();
        end
        mem_ack = 1'b0;
        chk("final_empty", empty, 1);
        for (int a = 0; a < 8; a++) chk("final_mem", bmem[a], arch[a]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
